// File: rtl/control_sequencer.sv
// control_sequencer: microcode sequencer for the 8-bit CPU.
// It steps through instruction T-states and decodes the opcode nibble plus
// the carry/zero flags into the 16-bit control word for the datapath.
// Build option: define CTRL_EARLY_STEP_RESET_EN to end each instruction right
// after its last non-zero micro-step instead of always running STEPS cycles.
// STEPS must lie in 5..8 so that the step number fits in o_step.

module control_sequencer #(
  parameter int STEPS = 5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_opcode,
  input  logic        i_flag_carry,
  input  logic        i_flag_zero,
  output logic [2:0]  o_step,
  output logic        o_halted,
  output logic [15:0] o_ctrl
);

  typedef enum logic [3:0] {
    OpNop = 4'h0,
    OpLda = 4'h1,
    OpAdd = 4'h2,
    OpSub = 4'h3,
    OpSta = 4'h4,
    OpLdi = 4'h5,
    OpJmp = 4'h6,
    OpJc  = 4'h7,
    OpJz  = 4'h8,
    OpOut = 4'hE,
    OpHlt = 4'hF
  } opcode_e;

  // Control word bit positions
  localparam logic [15:0] CtrlHlt = 16'h8000;
  localparam logic [15:0] CtrlMi  = 16'h4000;
  localparam logic [15:0] CtrlRi  = 16'h2000;
  localparam logic [15:0] CtrlRo  = 16'h1000;
  localparam logic [15:0] CtrlIo  = 16'h0800;
  localparam logic [15:0] CtrlIi  = 16'h0400;
  localparam logic [15:0] CtrlAi  = 16'h0200;
  localparam logic [15:0] CtrlAo  = 16'h0100;
  localparam logic [15:0] CtrlEo  = 16'h0080;
  localparam logic [15:0] CtrlSu  = 16'h0040;
  localparam logic [15:0] CtrlBi  = 16'h0020;
  localparam logic [15:0] CtrlOi  = 16'h0010;
  localparam logic [15:0] CtrlCe  = 16'h0008;
  localparam logic [15:0] CtrlCo  = 16'h0004;
  localparam logic [15:0] CtrlJ   = 16'h0002;
  localparam logic [15:0] CtrlFi  = 16'h0001;

  localparam logic [2:0] LastStep = 3'(STEPS - 1);

  opcode_e     op;
  logic [2:0]  step_q, step_d;
  logic        halted_q, halted_d;
  logic [2:0]  endStep;
  logic [15:0] ctrl;

  assign op = opcode_e'(i_opcode);

`ifdef CTRL_EARLY_STEP_RESET_EN
  logic [2:0] opLastStep;

  // Last micro-step that does real work for the current opcode; step 2 always runs
  always_comb begin
    opLastStep = 3'd2;
    case (op)
      OpLda, OpSta: opLastStep = 3'd3;
      OpAdd, OpSub: opLastStep = 3'd4;
      default:      opLastStep = 3'd2;
    endcase
  end

  assign endStep = (opLastStep < LastStep) ? opLastStep : LastStep;
`else
  assign endStep = LastStep;
`endif

  // Next-state for the step counter and halt latch; halting freezes the counter at 2
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (step_q == 3'd2 && op == OpHlt) begin
        halted_d = 1'b1;
      end else if (step_q >= endStep) begin
        step_d = 3'd0;
      end else begin
        step_d = step_q + 3'd1;
      end
    end
  end

  // Sequencer state registers, cleared asynchronously by reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      step_q   <= 3'd0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  // Control word decode: fetch is common, execute depends on opcode and flags
  always_comb begin
    ctrl = 16'h0000;
    if (halted_q) begin
      ctrl = CtrlHlt;
    end else begin
      case (step_q)
        3'd0: ctrl = CtrlMi | CtrlCo;
        3'd1: ctrl = CtrlRo | CtrlIi | CtrlCe;
        3'd2: begin
          case (op)
            OpLda, OpAdd, OpSub, OpSta: ctrl = CtrlIo | CtrlMi;
            OpLdi: ctrl = CtrlIo | CtrlAi;
            OpJmp: ctrl = CtrlIo | CtrlJ;
            OpJc:  ctrl = i_flag_carry ? (CtrlIo | CtrlJ) : 16'h0000;
            OpJz:  ctrl = i_flag_zero ? (CtrlIo | CtrlJ) : 16'h0000;
            OpOut: ctrl = CtrlAo | CtrlOi;
            OpHlt: ctrl = CtrlHlt;
            default: ctrl = 16'h0000;
          endcase
        end
        3'd3: begin
          case (op)
            OpLda:        ctrl = CtrlRo | CtrlAi;
            OpAdd, OpSub: ctrl = CtrlRo | CtrlBi;
            OpSta:        ctrl = CtrlAo | CtrlRi;
            default:      ctrl = 16'h0000;
          endcase
        end
        3'd4: begin
          case (op)
            OpAdd:   ctrl = CtrlEo | CtrlAi | CtrlFi;
            OpSub:   ctrl = CtrlEo | CtrlAi | CtrlSu | CtrlFi;
            default: ctrl = 16'h0000;
          endcase
        end
        default: ctrl = 16'h0000;
      endcase
    end
  end

  assign o_step   = step_q;
  assign o_halted = halted_q;
  assign o_ctrl   = ctrl;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed testbench for control_sequencer. Expected control words are
// hand-computed from the opcode table; instruction lengths follow the build
// (CTRL_EARLY_STEP_RESET_EN shortens instructions).

module tb_control_sequencer;

`ifdef CTRL_EARLY_STEP_RESET_EN
  localparam bit Early = 1'b1;
`else
  localparam bit Early = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [3:0]  opcode;
  logic        carry;
  logic        zero;
  logic [2:0]  step;
  logic        halted;
  logic [15:0] ctrl;

  int passCount  = 0;
  int checkCount = 0;

  control_sequencer #(.STEPS(5)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_opcode     (opcode),
    .i_flag_carry (carry),
    .i_flag_zero  (zero),
    .o_step       (step),
    .o_halted     (halted),
    .o_ctrl       (ctrl)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passCount, checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic checkState(input string tag, input logic [2:0] expStep,
                            input logic expHalted, input logic [15:0] expCtrl);
    checkOutput({tag, "_step"}, {13'd0, step}, {13'd0, expStep});
    checkOutput({tag, "_halted"}, {15'd0, halted}, {15'd0, expHalted});
    checkOutput({tag, "_ctrl"}, ctrl, expCtrl);
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic c, input logic z);
    opcode = op;
    carry  = c;
    zero   = z;
  endtask

  // Runs one whole instruction starting at a falling edge in step 0
  task automatic runInstr(input string tag, input logic [3:0] op, input logic c, input logic z,
                          input logic [15:0] t2, input logic [15:0] t3, input logic [15:0] t4,
                          input int earlyLen);
    int len;
    logic [15:0] e;
    len = Early ? earlyLen : 5;
    applyStimulus(op, c, z);
    for (int s = 0; s < len; s++) begin
      case (s)
        0: e = 16'h4004;
        1: e = 16'h1408;
        2: e = t2;
        3: e = t3;
        4: e = t4;
        default: e = 16'h0000;
      endcase
      checkState($sformatf("%s_t%0d", tag, s), 3'(s), 1'b0, e);
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(4'h0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 checkState("reset_async", 3'd0, 1'b0, 16'h4004);
    @(negedge clk);
    checkState("reset_held", 3'd0, 1'b0, 16'h4004);
    rst = 1'b0;

    runInstr("lda", 4'h1, 1'b0, 1'b0, 16'h4800, 16'h1200, 16'h0000, 4);

    // ADD interrupted by reset in the middle of T3
    applyStimulus(4'h2, 1'b0, 1'b0);
    checkState("addrst_t0", 3'd0, 1'b0, 16'h4004);
    @(negedge clk);
    checkState("addrst_t1", 3'd1, 1'b0, 16'h1408);
    @(negedge clk);
    checkState("addrst_t2", 3'd2, 1'b0, 16'h4800);
    @(negedge clk);
    checkState("addrst_t3", 3'd3, 1'b0, 16'h1020);
    #2 rst = 1'b1;
    #1 checkState("addrst_mid", 3'd0, 1'b0, 16'h4004);
    #1 rst = 1'b0;
    @(negedge clk);
    checkState("addrst_after_t1", 3'd1, 1'b0, 16'h1408);
    @(negedge clk);
    checkState("addrst_after_t2", 3'd2, 1'b0, 16'h4800);
    @(negedge clk);
    checkState("addrst_after_t3", 3'd3, 1'b0, 16'h1020);
    @(negedge clk);
    checkState("addrst_after_t4", 3'd4, 1'b0, 16'h0281);
    @(negedge clk);

    runInstr("add", 4'h2, 1'b0, 1'b0, 16'h4800, 16'h1020, 16'h0281, 5);
    runInstr("sub", 4'h3, 1'b1, 1'b1, 16'h4800, 16'h1020, 16'h02C1, 5);
    runInstr("sta", 4'h4, 1'b0, 1'b0, 16'h4800, 16'h2100, 16'h0000, 4);
    runInstr("ldi", 4'h5, 1'b0, 1'b0, 16'h0A00, 16'h0000, 16'h0000, 3);
    runInstr("jmp", 4'h6, 1'b0, 1'b0, 16'h0802, 16'h0000, 16'h0000, 3);
    runInstr("jc_taken", 4'h7, 1'b1, 1'b0, 16'h0802, 16'h0000, 16'h0000, 3);
    runInstr("jc_not", 4'h7, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 3);
    runInstr("jz_taken", 4'h8, 1'b0, 1'b1, 16'h0802, 16'h0000, 16'h0000, 3);
    runInstr("jz_not", 4'h8, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3);
    runInstr("out", 4'hE, 1'b0, 1'b0, 16'h0110, 16'h0000, 16'h0000, 3);
    runInstr("nop", 4'h0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3);
    runInstr("undef_b", 4'hB, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 3);

    // Flag changing during T2 must show up in the same cycle
    applyStimulus(4'h8, 1'b0, 1'b0);
    checkState("jzflip_t0", 3'd0, 1'b0, 16'h4004);
    @(negedge clk);
    checkState("jzflip_t1", 3'd1, 1'b0, 16'h1408);
    @(negedge clk);
    checkState("jzflip_t2_low", 3'd2, 1'b0, 16'h0000);
    zero = 1'b1;
    #1 checkState("jzflip_t2_high", 3'd2, 1'b0, 16'h0802);
    @(negedge clk);
    checkState("jzflip_next", Early ? 3'd0 : 3'd3, 1'b0, Early ? 16'h4004 : 16'h0000);
    if (!Early) repeat (2) @(negedge clk);

    // Halt, then hold while inputs wiggle, then reset out of it
    applyStimulus(4'hF, 1'b0, 1'b0);
    checkState("hlt_t0", 3'd0, 1'b0, 16'h4004);
    @(negedge clk);
    checkState("hlt_t1", 3'd1, 1'b0, 16'h1408);
    @(negedge clk);
    checkState("hlt_t2", 3'd2, 1'b0, 16'h8000);
    @(negedge clk);
    checkState("hlt_set", 3'd2, 1'b1, 16'h8000);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'h1, i[0], ~i[0]);
      @(negedge clk);
      checkState($sformatf("hlt_hold%0d", i), 3'd2, 1'b1, 16'h8000);
    end
    #2 rst = 1'b1;
    #1 checkState("hlt_reset", 3'd0, 1'b0, 16'h4004);
    #1 rst = 1'b0;
    @(negedge clk);
    checkState("hlt_restart", 3'd1, 1'b0, 16'h1408);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
